hazard_sequencer: RTL

- Central pipeline controller for the 5-stage RV32 core.
- Drives the enable and flush inputs of the IF, IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates the EX-stage operand forwarding selects.
- Sequences the multi-cycle multiplier through a start/done handshake with a timeout watchdog; keeps stall and flush event counters for performance debug.

---
 rtl/hazard_sequencer_pkg.sv | 54 +++++
 rtl/hazard_sequencer_mul_handshake_fsm.sv | 107 ++++++++++
 rtl/hazard_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings for the pipeline hazard sequencer. It holds
//               the EX-stage result-source codes, the operand forwarding
//               selects, the multiplier handshake state type and the operand
//               forwarding select function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Result source of the instruction currently in EX
    localparam logic [2:0] RES_ALU  = 3'b000;
    localparam logic [2:0] RES_LOAD = 3'b001;
    localparam logic [2:0] RES_PC4  = 3'b010;
    localparam logic [2:0] RES_IMM  = 3'b011;
    localparam logic [2:0] RES_MUL  = 3'b100;

    // EX operand select: register file, WB result, MEM ALU result
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The watchdog counter width covers the full MUL_TIMEOUT range (2..255)
    localparam int WDOG_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mul_state_t;

    // Forwarding select for one EX source operand. The younger MEM result
    // takes priority over WB. x0 is never forwarded because it is hardwired
    // to zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sequencer_mul_handshake_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mul_handshake_fsm
// Description : Start/done handshake with the multi-cycle multiplier. It
//               issues a one-cycle Mealy start pulse from IDLE and then waits
//               for mul_done. A watchdog forces release after MUL_TIMEOUT wait
//               cycles and latches a sticky error flag.
// Ports       : clk, reset (async, active-low)
//               MulE        - EX instruction is a multiply
//               mul_done    - multiplier result valid pulse
//               mul_start   - start pulse to the multiplier
//               mul_busy    - FSM not idle (or leaving idle this cycle)
//               mul_error   - sticky watchdog timeout flag
//               mul_stall   - pipeline must hold; busy and not releasing
//               mul_release - this cycle the product is released into MEM
// Revision    : 1.0 - initial release
// ============================================================================
module mul_handshake_fsm
    import hazard_pkg::*;
#(
    parameter int MUL_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic MulE,
    input  logic mul_done,
    output logic mul_start,
    output logic mul_busy,
    output logic mul_error,
    output logic mul_stall,
    output logic mul_release
);

    localparam logic [WDOG_W-1:0] c_WDOG_LAST = WDOG_W'(MUL_TIMEOUT - 1);

    mul_state_t        r_state;
    mul_state_t        w_state_nxt;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_error;
    logic              w_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The start pulse clears the watchdog, so the first WAIT cycle sees 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (mul_start) begin
            r_wdog <= '0;
        end else if (r_state == WAIT) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    // The outputs are forced idle while reset is held. This keeps a held
    // MulE from producing a start pulse or a busy indication during reset.
    always_comb begin
        w_state_nxt = r_state;
        mul_start   = 1'b0;
        mul_busy    = 1'b0;
        mul_release = 1'b0;
        w_timeout   = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    // mul_done arriving here (even with start) is ignored
                    if (MulE) begin
                        mul_start   = 1'b1;
                        mul_busy    = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    mul_busy = 1'b1;
                    if (mul_done) begin
                        mul_release = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        mul_release = 1'b1;
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign mul_stall = mul_busy & ~mul_release;
    assign mul_error = r_error;

endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Central pipeline controller for the 5-stage RV32 core. It
//               drives the pipeline register enables and flushes, the EX
//               operand forwarding selects and the multiplier handshake. It
//               also keeps the stall and flush performance counters.
// Ports       : clk, reset (async, active-low)
//               Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM, RdW - register specifiers
//               ResultSrcE, MulE, PCSrcE          - EX instruction info
//               RegWriteM, RegWriteW              - rf write flags
//               mul_done                          - multiplier result pulse
//               en_F/en_FD/en_DE/en_EM            - pipeline enables
//               flush_FD/flush_DE/flush_EM        - pipeline clears
//               ForwardAE/ForwardBE               - EX operand selects
//               mul_start/mul_busy/mul_error      - multiplier handshake
//               stall_cnt/flush_cnt               - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [2:0]       ResultSrcE,
    input  logic             MulE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             mul_done,
    output logic             en_F,
    output logic             en_FD,
    output logic             en_DE,
    output logic             en_EM,
    output logic             flush_FD,
    output logic             flush_DE,
    output logic             flush_EM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mul_start,
    output logic             mul_busy,
    output logic             mul_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_mul_stall;
    logic             w_mul_release;
    logic             w_load_use;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    mul_handshake_fsm #(
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) u_mul_fsm (
        .clk         (clk),
        .reset       (reset),
        .MulE        (MulE),
        .mul_done    (mul_done),
        .mul_start   (mul_start),
        .mul_busy    (mul_busy),
        .mul_error   (mul_error),
        .mul_stall   (w_mul_stall),
        .mul_release (w_mul_release)
    );

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign w_load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Priority is multiplier stall, then redirect, then load-use. In the
    // release cycle every stage advances with no clear, so EX/MEM captures
    // the product.
    always_comb begin
        en_F     = 1'b1;
        en_FD    = 1'b1;
        en_DE    = 1'b1;
        en_EM    = 1'b1;
        flush_FD = 1'b0;
        flush_DE = 1'b0;
        flush_EM = 1'b0;
        if (reset) begin
            if (w_mul_stall) begin
                // Hold IF..EX and push a bubble into MEM
                en_F     = 1'b0;
                en_FD    = 1'b0;
                en_DE    = 1'b0;
                flush_EM = 1'b1;
            end else if (w_mul_release) begin
                en_F = 1'b1;
            end else if (PCSrcE) begin
                flush_FD = 1'b1;
                flush_DE = 1'b1;
            end else if (w_load_use) begin
                en_F     = 1'b0;
                en_FD    = 1'b0;
                flush_DE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!en_FD) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (flush_FD) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
